// File: rtl/vproc_bus_slave.sv
// Memory-mapped responder for the VProc virtual processor: local word RAM, a
// one-channel interrupt timer, wait-stated single-cycle acks and the Update mirror.
module vproc_bus_slave #(
    parameter int          MEM_ADDR_BITS = 10,
    parameter int          WAIT_STATES   = 1,
    parameter logic [31:0] ERR_DATA      = 32'hDEADBEEF
) (
    input  logic        Clk,
    input  logic        nReset,
    input  logic [31:0] Addr,
    input  logic        WE,
    input  logic        RD,
    input  logic [31:0] DataOut,
    input  logic        Update,
    output logic        UpdateResponse,
    output logic [31:0] DataIn,
    output logic        WRAck,
    output logic        RDAck,
    output logic [2:0]  Interrupt
);

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    state_t                     state_q, state_d;
    logic [3:0]                 wcnt_q, wcnt_d;
    logic                       capture, access;

    logic [3:0]                 region_q;
    logic [MEM_ADDR_BITS-1:0]   idx_q;
    logic [31:0]                wdata_q;
    logic                       wr_q;

    logic [31:0]                mem [2**MEM_ADDR_BITS];
    logic [31:0]                rdata;

    logic [31:0]                load_q, count_q;
    logic                       en_q, auto_q, pending_q;
    logic [2:0]                 level_q;
    logic                       tmr_wr, ld_wr, ctl_wr, st_wr, tick, expire;

    logic                       addr_unused;
    assign addr_unused = ^{Addr[27:MEM_ADDR_BITS+2], Addr[1:0]};

    assign UpdateResponse = Update & nReset;
    assign Interrupt      = pending_q ? level_q : 3'b0;

    // A zero-wait access still spends one edge in WAIT so the access uses the
    // latched request; the ack therefore never lands on the capture edge.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        capture = 1'b0;
        access  = 1'b0;
        case (state_q)
            IDLE: begin
                if (WE | RD) begin
                    capture = 1'b1;
                    state_d = WAIT;
                    wcnt_d  = WS;
                end
            end
            WAIT: begin
                if (wcnt_q <= 4'd1) begin
                    access  = 1'b1;
                    state_d = ACK;
                    wcnt_d  = 4'd0;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rdata = ERR_DATA;
        case (region_q)
            4'h0: rdata = mem[idx_q];
            4'hA: begin
                case (idx_q[1:0])
                    2'd0:    rdata = load_q;
                    2'd1:    rdata = {27'b0, level_q, auto_q, en_q};
                    2'd2:    rdata = count_q;
                    default: rdata = {31'b0, pending_q};
                endcase
            end
            default: rdata = ERR_DATA;
        endcase
    end

    assign tmr_wr = access & wr_q & (region_q == 4'hA);
    assign ld_wr  = tmr_wr & (idx_q[1:0] == 2'd0);
    assign ctl_wr = tmr_wr & (idx_q[1:0] == 2'd1);
    assign st_wr  = tmr_wr & (idx_q[1:0] == 2'd3);
    assign tick   = en_q & (count_q != 32'd0);
    assign expire = tick & (count_q == 32'd1);

    always_ff @(posedge Clk) begin
        if (capture) begin
            region_q <= Addr[31:28];
            idx_q    <= Addr[MEM_ADDR_BITS+1:2];
            wdata_q  <= DataOut;
            wr_q     <= WE;
        end
        if (access && wr_q && region_q == 4'h0)
            mem[idx_q] <= wdata_q;
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q   <= IDLE;
            wcnt_q    <= 4'd0;
            DataIn    <= 32'd0;
            WRAck     <= 1'b0;
            RDAck     <= 1'b0;
            load_q    <= 32'd0;
            count_q   <= 32'd0;
            en_q      <= 1'b0;
            auto_q    <= 1'b0;
            level_q   <= 3'd0;
            pending_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            WRAck   <= access & wr_q;
            RDAck   <= access & ~wr_q;
            if (access && !wr_q)
                DataIn <= rdata;

            if (ld_wr)
                load_q <= wdata_q;

            // A CTRL write takes precedence over the expiry reload/disable.
            if (ctl_wr) begin
                en_q    <= wdata_q[0];
                auto_q  <= wdata_q[1];
                level_q <= wdata_q[4:2];
            end else if (expire && !auto_q) begin
                en_q <= 1'b0;
            end

            if (ctl_wr && wdata_q[0])
                count_q <= load_q;
            else if (expire)
                count_q <= auto_q ? load_q : 32'd0;
            else if (tick)
                count_q <= count_q - 32'd1;

            if (expire)
                pending_q <= 1'b1;
            else if (st_wr)
                pending_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vproc_bus_slave.sv
// Bench for vproc_bus_slave: two instances (1 and 0 wait states) share the bus
// inputs; read data is scoreboarded and ack/timer timing is checked per edge.
module tb_vproc_bus_slave;

    logic        Clk = 1'b0;
    logic        nReset;
    logic [31:0] Addr;
    logic        WE;
    logic        RD;
    logic [31:0] DataOut;
    logic        Update;

    logic        ur   [2];
    logic [31:0] din  [2];
    logic        wack [2];
    logic        rack [2];
    logic [2:0]  intr [2];

    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] rd_q [$];

    vproc_bus_slave #(.MEM_ADDR_BITS(10), .WAIT_STATES(0), .ERR_DATA(32'hDEADBEEF)) dut0 (
        .Clk(Clk), .nReset(nReset), .Addr(Addr), .WE(WE), .RD(RD), .DataOut(DataOut),
        .Update(Update), .UpdateResponse(ur[0]), .DataIn(din[0]), .WRAck(wack[0]),
        .RDAck(rack[0]), .Interrupt(intr[0])
    );

    vproc_bus_slave #(.MEM_ADDR_BITS(10), .WAIT_STATES(1), .ERR_DATA(32'hDEADBEEF)) dut1 (
        .Clk(Clk), .nReset(nReset), .Addr(Addr), .WE(WE), .RD(RD), .DataOut(DataOut),
        .Update(Update), .UpdateResponse(ur[1]), .DataIn(din[1]), .WRAck(wack[1]),
        .RDAck(rack[1]), .Interrupt(intr[1])
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    // Edges from capture to ack: sel 0 has zero wait states, sel 1 has one.
    function automatic int exp_lat(input int sel);
        int ws;
        ws = (sel == 0) ? 0 : 1;
        return (ws == 0) ? 1 : ws;
    endfunction

    // Entered just after a falling edge; returns one falling edge after the ack.
    task automatic do_access(input string nm, input int sel, input bit wr,
                             input logic [31:0] a, input logic [31:0] d,
                             input logic [31:0] exp_rd, output int ack_edge);
        int          cap;
        bit          got;
        logic [31:0] exp;
        Addr = a; DataOut = d; WE = wr; RD = !wr;
        if (!wr) rd_q.push_back(exp_rd);
        cap = cyc + 1;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge Clk);
            if (wack[sel] || rack[sel]) got = 1'b1;
        end
        ack_edge = cyc;
        WE = 1'b0; RD = 1'b0;
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL %s_timeout: no ack, got none want ack within 40 edges", nm);
            if (!wr) exp = rd_q.pop_front();
        end else begin
            if (cyc - cap !== exp_lat(sel)) begin
                failures++;
                $display("FAIL %s_latency: got %0d want %0d", nm, cyc - cap, exp_lat(sel));
            end
            checks++;
            if ({wack[sel], rack[sel]} !== (wr ? 2'b10 : 2'b01)) begin
                failures++;
                $display("FAIL %s_acktype: got %b want %b", nm, {wack[sel], rack[sel]}, wr ? 2'b10 : 2'b01);
            end
            if (!wr) begin
                exp = rd_q.pop_front();
                checks++;
                if (din[sel] !== exp) begin
                    failures++;
                    $display("FAIL %s_data: got %h want %h", nm, din[sel], exp);
                end
            end
            @(negedge Clk);
            checks++;
            if ((wack[sel] | rack[sel]) !== 1'b0) begin
                failures++;
                $display("FAIL %s_ackwidth: got %b want 0", nm, wack[sel] | rack[sel]);
            end
        end
    endtask

    task automatic test_reset();
        nReset = 1'b0; WE = 1'b0; RD = 1'b0; Addr = '0; DataOut = '0; Update = 1'b0;
        repeat (2) @(negedge Clk);
        for (int s = 0; s < 2; s++) begin
            checks++;
            if ({wack[s], rack[s], ur[s], intr[s], din[s]} !== 38'd0) begin
                failures++;
                $display("FAIL reset_outputs%0d: got %h want 0", s,
                         {wack[s], rack[s], ur[s], intr[s], din[s]});
            end
        end
        nReset = 1'b1;
        @(negedge Clk);
    endtask

    task automatic test_update_mirror();
        Update = 1'b1;
        #1;
        checks++;
        if ({ur[1], ur[0]} !== 2'b11) begin
            failures++;
            $display("FAIL update_rise: got %b want 11", {ur[1], ur[0]});
        end
        Update = 1'b0;
        #1;
        checks++;
        if ({ur[1], ur[0]} !== 2'b00) begin
            failures++;
            $display("FAIL update_fall: got %b want 00", {ur[1], ur[0]});
        end
        @(negedge Clk);
    endtask

    task automatic test_write_read();
        int e;
        do_access("wr_10", 1, 1'b1, 32'h0000_0010, 32'h1234_5678, '0, e);
        do_access("rd_10", 1, 1'b0, 32'h0000_0010, '0, 32'h1234_5678, e);
        do_access("wr_00", 1, 1'b1, 32'h0000_0000, 32'hA5A5_0000, '0, e);
        do_access("wr_04", 1, 1'b1, 32'h0000_0004, 32'h0000_5A5A, '0, e);
        do_access("rd_alias", 1, 1'b0, 32'h0000_1000, '0, 32'hA5A5_0000, e);
    endtask

    task automatic test_back_to_back();
        int          a1, a2;
        bit          got;
        logic [31:0] exp;
        RD = 1'b1; Addr = 32'h0; rd_q.push_back(32'hA5A5_0000);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge Clk);
            if (rack[0]) got = 1'b1;
        end
        a1 = cyc;
        exp = rd_q.pop_front();
        checks++;
        if (din[0] !== exp || !got) begin
            failures++;
            $display("FAIL b2b_first: got %h want %h", din[0], exp);
        end
        Addr = 32'h4; rd_q.push_back(32'h0000_5A5A);
        @(negedge Clk);
        checks++;
        if (rack[0] !== 1'b0) begin
            failures++;
            $display("FAIL b2b_stale: got %b want 0", rack[0]);
        end
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge Clk);
            if (rack[0]) got = 1'b1;
        end
        a2 = cyc;
        RD = 1'b0;
        exp = rd_q.pop_front();
        checks++;
        if (a2 - a1 !== 3) begin
            failures++;
            $display("FAIL b2b_spacing: got %0d want 3", a2 - a1);
        end
        checks++;
        if (din[0] !== exp) begin
            failures++;
            $display("FAIL b2b_second: got %h want %h", din[0], exp);
        end
        repeat (2) begin
            @(negedge Clk);
            checks++;
            if ((rack[0] | wack[0]) !== 1'b0) begin
                failures++;
                $display("FAIL b2b_dup: got %b want 0", rack[0] | wack[0]);
            end
        end
    endtask

    task automatic test_unmapped();
        int e;
        do_access("rd_unmapped", 1, 1'b0, 32'h5000_0000, '0, 32'hDEAD_BEEF, e);
        do_access("wr_unmapped", 1, 1'b1, 32'h5000_0000, 32'hFFFF_FFFF, '0, e);
        do_access("rd_ram0", 1, 1'b0, 32'h0000_0000, '0, 32'hA5A5_0000, e);
        do_access("rd_ram4", 1, 1'b0, 32'h0000_0004, '0, 32'h0000_5A5A, e);
    endtask

    task automatic test_timer_oneshot();
        int e, ce, pred;
        do_access("ld5", 1, 1'b1, 32'hA000_0000, 32'd5, '0, e);
        do_access("ctl_0d", 1, 1'b1, 32'hA000_0004, 32'h0000_000D, '0, ce);
        pred = cyc + 1 + exp_lat(1);
        do_access("count_run", 1, 1'b0, 32'hA000_0008, '0, 32'(5 - (pred - 1 - ce)), e);
        checks++;
        if (intr[1] !== 3'd0) begin
            failures++;
            $display("FAIL irq_early: got %0d want 0 at edge %0d", intr[1], cyc - ce);
        end
        while (cyc < ce + 5) @(negedge Clk);
        checks++;
        if (intr[1] !== 3'd3) begin
            failures++;
            $display("FAIL irq_fire: got %0d want 3", intr[1]);
        end
        do_access("ctl_en_clr", 1, 1'b0, 32'hA000_0004, '0, 32'h0000_000C, e);
        do_access("status_set", 1, 1'b0, 32'hA000_000C, '0, 32'h1, e);
        do_access("count_zero", 1, 1'b0, 32'hA000_0008, '0, 32'h0, e);
        do_access("status_clr", 1, 1'b1, 32'hA000_000C, 32'h0, '0, e);
        checks++;
        if (intr[1] !== 3'd0) begin
            failures++;
            $display("FAIL irq_clear: got %0d want 0", intr[1]);
        end
    endtask

    task automatic test_timer_auto();
        int e, ce, pred;
        do_access("ld3", 1, 1'b1, 32'hA000_0000, 32'd3, '0, e);
        do_access("ctl_07", 1, 1'b1, 32'hA000_0004, 32'h0000_0007, '0, ce);
        // STATUS write lands on the first expiry edge (ce+3)
        do_access("status_collide", 1, 1'b1, 32'hA000_000C, 32'h0, '0, e);
        checks++;
        if (e !== ce + 3 || intr[1] !== 3'd1) begin
            failures++;
            $display("FAIL set_wins: got irq %0d at edge %0d want 1 at %0d", intr[1], e - ce, 3);
        end
        pred = cyc + 1 + exp_lat(1);
        do_access("count_reload", 1, 1'b0, 32'hA000_0008, '0, 32'(3 - ((pred - 1 - ce) % 3)), e);
        while (cyc < ce + 8) @(negedge Clk);
        do_access("status_clr2", 1, 1'b1, 32'hA000_000C, 32'h0, '0, e);
        checks++;
        if (intr[1] !== 3'd0) begin
            failures++;
            $display("FAIL auto_clear: got %0d want 0", intr[1]);
        end
        while (cyc < ce + 12) @(negedge Clk);
        checks++;
        if (intr[1] !== 3'd1) begin
            failures++;
            $display("FAIL auto_period: got %0d want 1", intr[1]);
        end
        do_access("ctl_off", 1, 1'b1, 32'hA000_0004, 32'h0, '0, e);
        do_access("status_clr3", 1, 1'b1, 32'hA000_000C, 32'h0, '0, e);
    endtask

    task automatic test_reset_mid_access();
        int e;
        do_access("wr_08", 1, 1'b1, 32'h0000_0008, 32'h1111_2222, '0, e);
        do_access("rd_08", 1, 1'b0, 32'h0000_0008, '0, 32'h1111_2222, e);
        Addr = 32'h8; DataOut = 32'hCAFE_F00D; WE = 1'b1;
        @(posedge Clk);
        #2;
        nReset = 1'b0;
        #1;
        checks++;
        if ({wack[1], rack[1], ur[1], intr[1], din[1]} !== 38'd0) begin
            failures++;
            $display("FAIL reset_async: got %h want 0", {wack[1], rack[1], ur[1], intr[1], din[1]});
        end
        Update = 1'b1;
        #1;
        checks++;
        if ({ur[1], ur[0]} !== 2'b00) begin
            failures++;
            $display("FAIL update_in_reset: got %b want 00", {ur[1], ur[0]});
        end
        repeat (2) @(negedge Clk);
        WE = 1'b0;
        nReset = 1'b1;
        @(negedge Clk);
        checks++;
        if ({wack[1], rack[1], ur[1]} !== 3'b001) begin
            failures++;
            $display("FAIL reset_release: got %b want 001", {wack[1], rack[1], ur[1]});
        end
        do_access("rd_08_kept", 1, 1'b0, 32'h0000_0008, '0, 32'h1111_2222, e);
    endtask

    initial begin
        test_reset();
        test_update_mirror();
        test_write_read();
        test_back_to_back();
        test_unmapped();
        test_timer_oneshot();
        test_timer_auto();
        test_reset_mid_access();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
